// File: rtl/chopper_pkg.sv
// Shared definitions for the chopper array: channel state encoding, leg indices
// and the gate pattern each state drives onto an H-bridge.
package chopper_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BLANK    = 3'd1,
    ON       = 3'd2,
    OFF_FAST = 3'd3,
    OFF_SLOW = 3'd4
  } chop_state_t;

  localparam int LEG1 = 0;
  localparam int LEG2 = 1;

  typedef struct packed {
    logic [1:0] h;
    logic [1:0] l;
  } gates_t;

  // polarity=1 swaps which leg plays the "drive-high" role
  function automatic gates_t gate_pattern(input chop_state_t st, input logic pol);
    gates_t g;
    logic   a;
    logic   b;
    g = '0;
    a = pol ? 1'(LEG2) : 1'(LEG1);
    b = ~a;
    case (st)
      BLANK, ON: begin
        g.h[a] = 1'b1;
        g.l[b] = 1'b1;
      end
      OFF_FAST: begin
        g.h[b] = 1'b1;
        g.l[a] = 1'b1;
      end
      OFF_SLOW: g.l = 2'b11;
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/chopper_channel.sv
// One peak-current regulator: comparator synchroniser, blank/on/off FSM with
// blank, minimum-on and off timers, and the consecutive-short counter.
module chopper_channel
  import chopper_pkg::*;
#(
  parameter int OFF_W        = 10,
  parameter int BLANK_W      = 8,
  parameter int MINON_W      = 8,
  parameter int FAULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [OFF_W-1:0]   config_offtime,
  input  logic [OFF_W-1:0]   config_fastdecay_threshold,
  input  logic [BLANK_W-1:0] config_blanktime,
  input  logic [MINON_W-1:0] config_minimum_on_time,
  input  logic               polarity,
  input  logic               analog_cmp,
  output chop_state_t        state,
  output logic               pol_q,
  output logic               cycle_done,
  output logic               short_hit
);

  localparam int SC_W = $clog2(FAULT_CYCLES + 1);

  logic               cmp_p0;
  logic               cmp_p1;
  logic [BLANK_W-1:0] blank_cnt;
  logic [MINON_W-1:0] minon_cnt;
  logic [OFF_W-1:0]   off_cnt;
  logic [SC_W-1:0]    short_cnt;
  logic               first_on;

  logic               blank_done;
  logic               minon_done;
  logic               off_done;
  logic               fast_all;
  logic [OFF_W-1:0]   fast_len;
  logic [OFF_W-1:0]   slow_len;

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v >= SC_W'(FAULT_CYCLES)) ? v : v + SC_W'(1);
  endfunction

  // A counter loaded with N covers max(N,1) cycles: it is done once it reads 0 or 1.
  assign blank_done = (blank_cnt <= BLANK_W'(1));
  assign minon_done = (minon_cnt <= MINON_W'(1));
  assign off_done   = (off_cnt <= OFF_W'(1));
  assign fast_all   = (config_fastdecay_threshold >= config_offtime);
  assign fast_len   = fast_all ? config_offtime : config_fastdecay_threshold;
  assign slow_len   = config_offtime - config_fastdecay_threshold;
  assign short_hit  = (short_cnt >= SC_W'(FAULT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pol_q      <= 1'b0;
      cycle_done <= 1'b0;
      cmp_p0     <= 1'b0;
      cmp_p1     <= 1'b0;
      blank_cnt  <= '0;
      minon_cnt  <= '0;
      off_cnt    <= '0;
      short_cnt  <= '0;
      first_on   <= 1'b0;
    end else begin
      cmp_p0     <= analog_cmp;
      cmp_p1     <= cmp_p0;
      pol_q      <= polarity;
      cycle_done <= 1'b0;
      if (!run) begin
        state     <= IDLE;
        blank_cnt <= '0;
        minon_cnt <= '0;
        off_cnt   <= '0;
        short_cnt <= '0;
        first_on  <= 1'b0;
      end else if (state == IDLE || polarity != pol_q) begin
        // start-up and direction reversal both restart a fresh chop cycle
        state     <= BLANK;
        blank_cnt <= config_blanktime;
        minon_cnt <= config_minimum_on_time;
        first_on  <= 1'b0;
      end else begin
        if (!minon_done) minon_cnt <= minon_cnt - MINON_W'(1);
        case (state)
          BLANK: begin
            if (blank_done) begin
              state    <= ON;
              first_on <= 1'b1;
            end else begin
              blank_cnt <= blank_cnt - BLANK_W'(1);
            end
          end
          ON: begin
            first_on <= 1'b0;
            if (first_on) short_cnt <= cmp_p1 ? sat_inc(short_cnt) : '0;
            if (cmp_p1 && minon_done) begin
              if (config_fastdecay_threshold != '0) begin
                state   <= OFF_FAST;
                off_cnt <= fast_len;
              end else begin
                state   <= OFF_SLOW;
                off_cnt <= config_offtime;
              end
            end
          end
          OFF_FAST: begin
            if (!off_done) begin
              off_cnt <= off_cnt - OFF_W'(1);
            end else if (fast_all) begin
              state      <= BLANK;
              blank_cnt  <= config_blanktime;
              minon_cnt  <= config_minimum_on_time;
              cycle_done <= 1'b1;
            end else begin
              state   <= OFF_SLOW;
              off_cnt <= slow_len;
            end
          end
          OFF_SLOW: begin
            if (!off_done) begin
              off_cnt <= off_cnt - OFF_W'(1);
            end else begin
              state      <= BLANK;
              blank_cnt  <= config_blanktime;
              minon_cnt  <= config_minimum_on_time;
              cycle_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/chopper_array.sv
// N-channel peak-current chopper: per-channel regulators, shared short-fault
// latch and registered gate outputs. Define CHOPPER_DEADTIME_EN for dead-time insertion.
module chopper_array
  import chopper_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int OFF_W        = 10,
  parameter int BLANK_W      = 8,
  parameter int MINON_W      = 8,
  parameter int FAULT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [OFF_W-1:0]     config_offtime,
  input  logic [OFF_W-1:0]     config_fastdecay_threshold,
  input  logic [BLANK_W-1:0]   config_blanktime,
  input  logic [MINON_W-1:0]   config_minimum_on_time,
  input  logic [3:0]           config_deadtime,
  input  logic [NCH-1:0]       polarity,
  input  logic [NCH-1:0]       analog_cmp,
  output logic [2*NCH-1:0]     drive_h,
  output logic [2*NCH-1:0]     drive_l,
  output logic [3*NCH-1:0]     chop_state,
  output logic [NCH-1:0]       cycle_done,
  output logic                 faultn
);

  chop_state_t      st [NCH];
  gates_t           pat [NCH];
  logic [NCH-1:0]   pol_q;
  logic [NCH-1:0]   short_hit;
  logic             fault_latch;
  logic             run;
  logic [2*NCH-1:0] gate_h_p1;
  logic [2*NCH-1:0] gate_l_p1;

  // a channel reaching the short limit stops every channel in the same cycle it latches
  assign run    = enable && !(fault_latch || (|short_hit));
  assign faultn = ~fault_latch;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    chopper_channel #(
      .OFF_W        (OFF_W),
      .BLANK_W      (BLANK_W),
      .MINON_W      (MINON_W),
      .FAULT_CYCLES (FAULT_CYCLES)
    ) u_ch (
      .clk                        (clk),
      .reset                      (reset),
      .run                        (run),
      .config_offtime             (config_offtime),
      .config_fastdecay_threshold (config_fastdecay_threshold),
      .config_blanktime           (config_blanktime),
      .config_minimum_on_time     (config_minimum_on_time),
      .polarity                   (polarity[i]),
      .analog_cmp                 (analog_cmp[i]),
      .state                      (st[i]),
      .pol_q                      (pol_q[i]),
      .cycle_done                 (cycle_done[i]),
      .short_hit                  (short_hit[i])
    );
    assign chop_state[3*i +: 3] = st[i];
    assign pat[i]               = gate_pattern(st[i], pol_q[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               fault_latch <= 1'b0;
    else if (!enable)        fault_latch <= 1'b0;
    else if (|short_hit)     fault_latch <= 1'b1;
  end

  // gate stage: one cycle behind the state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_h_p1 <= '0;
      gate_l_p1 <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        gate_h_p1[2*i +: 2] <= pat[i].h;
        gate_l_p1[2*i +: 2] <= pat[i].l;
      end
    end
  end

`ifdef CHOPPER_DEADTIME_EN
  logic [2*NCH-1:0][3:0] h_off;
  logic [2*NCH-1:0][3:0] l_off;
  logic [3:0]            dt_min;

  assign dt_min = (config_deadtime == 4'd0) ? 4'd1 : config_deadtime;

  // turn-off passes straight through; turn-on waits for the partner gate's idle count
  for (genvar j = 0; j < 2*NCH; j++) begin : g_dt
    assign drive_h[j] = gate_h_p1[j] && (l_off[j] >= dt_min);
    assign drive_l[j] = gate_l_p1[j] && (h_off[j] >= dt_min);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_off <= '0;
      l_off <= '0;
    end else begin
      for (int j = 0; j < 2*NCH; j++) begin
        h_off[j] <= drive_h[j] ? 4'd0 : ((h_off[j] == 4'hf) ? h_off[j] : h_off[j] + 4'd1);
        l_off[j] <= drive_l[j] ? 4'd0 : ((l_off[j] == 4'hf) ? l_off[j] : l_off[j] + 4'd1);
      end
    end
  end
`else
  logic deadtime_unused;
  assign deadtime_unused = ^config_deadtime;
  assign drive_h         = gate_h_p1;
  assign drive_l         = gate_l_p1;
`endif

endmodule

// File: doc/chopper_array.md
Name: chopper_array

Overview:
- Parametrised N-channel peak-current chopper for H-bridge stepper phases.
- Replaces the fixed two-phase off/blank/minimum-on timer cluster with one self-contained regulator per channel.
- Each channel has a blank → on → fast-decay → slow-decay cycle and consecutive-short fault detection.
- Sits between the microstep counter (phase polarity), the analog current comparators, and the gate-drive inversion stage.

Parameters:
NCH, 2, number of bridge channels (phases)
OFF_W, 10, width of off-time and fast-decay counters
BLANK_W, 8, width of blank counter
MINON_W, 8, width of minimum-on counter
FAULT_CYCLES, 4, consecutive short chop cycles that latch a fault (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  global bridge enable; low forces all channels idle and clears fault
config_offtime  in  OFF_W  off-phase length in cycles
config_fastdecay_threshold  in  OFF_W  fast-decay cycles at start of off phase
config_blanktime  in  BLANK_W  comparator blanking after turn-on
config_minimum_on_time  in  MINON_W  minimum drive time from turn-on
config_deadtime  in  4  dead-time cycles (used only with the optional feature)
polarity  in  NCH  per-channel current direction (0 = leg1 high)
analog_cmp  in  NCH  1 = phase current above threshold
drive_h  out  2*NCH  high-side gates, {leg2,leg1} per channel, active-high
drive_l  out  2*NCH  low-side gates, same ordering
chop_state  out  3*NCH  per-channel state encoding, for debug
cycle_done  out  NCH  one-cycle pulse at each off→blank transition
faultn  out  1  low = latched short fault

Behaviour:
- Reset values:
  - drive_h, drive_l, chop_state = 0 (IDLE), cycle_done = 0, faultn = 1.
  - All counters and fault counters = 0.
- Per-channel FSM states: IDLE=0, BLANK=1, ON=2, OFF_FAST=3, OFF_SLOW=4.
- Timer rule: a state loaded with value N lasts max(N,1) cycles. Counters load on state entry and count down.
- IDLE → BLANK: on the first cycle with enable=1 and fault clear. Blank and min-on counters load.
- BLANK: comparator ignored. When the blank count expires → ON.
- ON: exit when analog_cmp=1 and min-on has expired; the min-on count runs from BLANK entry.
  - Exit to OFF_FAST if config_fastdecay_threshold ≠ 0, else to OFF_SLOW.
  - Off counter loads config_offtime on exit.
- OFF_FAST: lasts min(threshold, offtime) cycles, then → OFF_SLOW for the remainder.
  - If threshold ≥ offtime, the whole off time is fast.
- OFF_SLOW: when off time expires → BLANK. Timers reload and cycle_done pulses for one cycle.
- Bridge mapping for polarity=0 (legs swap when polarity=1):
  - BLANK/ON: h1, l2.
  - OFF_FAST: h2, l1.
  - OFF_SLOW: l1, l2.
  - IDLE: all gates off.
- Output latency: gate outputs are registered, one cycle after the state register.
- Polarity change in any non-IDLE state: the channel goes to BLANK next cycle with all timers reloaded. No cycle_done pulse.
- Short detection:
  - A chop cycle is "short" if analog_cmp=1 on the first ON cycle after BLANK.
  - Each channel has a saturating count of consecutive short cycles; any non-short cycle clears it.
  - When any channel's count reaches FAULT_CYCLES: faultn goes 0 next cycle and all channels go to IDLE.
  - The fault stays latched until enable=0.
- enable=0: all channels IDLE next cycle, gates 0 one cycle later, fault and short counts cleared.
- Simultaneous events:
  - Fault latch and polarity change: fault wins.
  - enable=0 and fault: enable wins, so the fault is cleared.
- Async reset mid-operation: all gates off immediately (asynchronously); no glitch to on.
- Comparator input is passed through a 2-flop synchroniser before use; this adds 2 cycles to the cmp response.

Optional Feature:
- Macro: CHOPPER_DEADTIME_EN.
- Defined:
  - Each gate output passes through a dead-time stage: turn-off is immediate.
  - Turn-on is delayed until the complementary gate of the same leg has been off for config_deadtime cycles; 0 means one cycle.
  - A leg's high and low gates are never both 1.
- Undefined: config_deadtime is ignored, and gates follow the mapping with the fixed one-cycle latency.

Decomposition:
- Package chopper_pkg: state encodings (IDLE..OFF_SLOW), the leg-index constants LEG1=0/LEG2=1, and a gate-pattern function of (state, polarity).
- Sub-module chopper_channel: FSM, three counters, short counter and synchroniser. It is instantiated NCH times under generate.
- Top level: fault OR/latch, enable handling, output packing and the optional dead-time stage.

Test Plan:
- Regulation: offtime=20, blank=5, minon=8, fast=0, NCH=2. Raise cmp on ON cycle 12 → OFF_SLOW (l1,l2) for 20 cycles, then cycle_done pulses and BLANK h1,l2 returns.
- Fast decay: fast=6, offtime=20 → h2,l1 for 6 cycles, then l1,l2 for 14. Repeat with fast=30 → 20 fast cycles, no slow.
- Minimum-on: minon=15, blank=5, cmp held high from blank end → ON lasts until cycle 15 from BLANK entry, then off.
- Short fault: FAULT_CYCLES=4, cmp stuck high → faultn=0 after the 4th short cycle and all gates 0. Drop enable for 1 cycle → faultn=1 and the channel restarts in BLANK.
- Polarity flip in OFF_SLOW on ch1 → next cycle BLANK with h2,l1 and no cycle_done. Ch0 is unaffected.
- CHOPPER_DEADTIME_EN, deadtime=3: ON→OFF_FAST → h1 off immediately, l1 on 3 cycles later. Assert the leg high/low never both 1 over a 10k-cycle random run.
